hpi_bus_master: RTL and testbench
=================================

HPI_BUS_MASTER -- requirements
Module: hpi_bus_master

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning host-port data width.
REQ-002 The block SHALL have parameter ADDR_W, default 2, meaning host-port address width.
REQ-003 The block SHALL have parameter SETUP_CYC, default 1 (range 1..15), meaning cycles with CS_N low and strobe high before the strobe.
REQ-004 The block SHALL have parameter STROBE_CYC, default 2 (range 1..15), meaning cycles with RD_N or WR_N low.
REQ-005 The block SHALL have parameter HOLD_CYC, default 1 (range 1..15), meaning cycles with CS_N low and strobe high after the strobe.
REQ-006 The block SHALL have parameter RST_CYC, default 4 (range 1..255), meaning cycles OTG_RST_N stays low after Reset deasserts.
REQ-007 The block SHALL have these ports (name, direction, width, meaning):
- Clk  in  1  single clock; all flops on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid when rsp_valid=1 for a read.
- irq_level  out  1  synchronised OTG_INT.
- irq_pulse  out  1  one-cycle pulse on an irq_level rising edge.
- OTG_DATA  inout  DATA_W  host-port data bus.
- OTG_ADDR  out  ADDR_W  host-port address.
- OTG_RD_N, OTG_WR_N, OTG_CS_N  out  1 each  active-low strobes and chip select.
- OTG_RST_N  out  1  active-low device reset.
- OTG_INT  in  1  asynchronous device interrupt.

Function
REQ-008 The FSM SHALL have five states: RSTWAIT, IDLE, SETUP, STROBE, HOLD.
REQ-009 RSTWAIT: OTG_RST_N=0 and req_ready=0; a counter counts RST_CYC cycles from Reset deassertion, then the FSM moves to IDLE with OTG_RST_N=1.
REQ-010 IDLE: req_ready=1 and all strobes and OTG_CS_N are 1; when req_valid=1, the block latches addr, wdata and write, and the FSM moves to SETUP on the next edge.
REQ-011 req_ready SHALL be 1 only in IDLE. A request is accepted only when req_valid and req_ready are both 1; no request is queued otherwise.
REQ-012 SETUP: OTG_CS_N=0, OTG_ADDR=latched addr, strobes 1, for exactly SETUP_CYC cycles.
REQ-013 STROBE: OTG_CS_N=0, for exactly STROBE_CYC cycles. OTG_RD_N=0 for a read; OTG_WR_N=0 for a write. The other strobe stays 1.
REQ-014 HOLD: OTG_CS_N=0, strobes 1, address held, for exactly HOLD_CYC cycles; then the FSM returns to IDLE.
REQ-015 All OTG_* outputs except OTG_DATA SHALL be driven from flops (glitch-free).
REQ-016 OTG_DATA SHALL carry the latched wdata only during SETUP, STROBE and HOLD of a write; it SHALL be high-impedance at all other times, including during every read and in reset.
REQ-017 Read data SHALL be captured from OTG_DATA on the clock edge that ends the last STROBE cycle, and held in rsp_rdata until the next read capture.
REQ-018 rsp_valid SHALL pulse high for exactly one cycle: the first IDLE cycle after HOLD, for both reads and writes.
REQ-019 Latency from the accepting edge to rsp_valid high SHALL be SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles. Back-to-back requests SHALL be accepted in that rsp_valid cycle.
REQ-020 OTG_INT SHALL pass through a two-flop synchroniser to give irq_level. irq_pulse SHALL be high for one cycle when irq_level goes 0->1.
REQ-021 Parameter values outside their ranges SHALL be a compile-time error.

Reset
REQ-022 Reset=1 SHALL immediately and asynchronously force:
- state RSTWAIT; OTG_RST_N=0
- OTG_CS_N=OTG_RD_N=OTG_WR_N=1; OTG_ADDR=0; OTG_DATA=Z
- req_ready=0, rsp_valid=0, rsp_rdata=0
- irq_level=0, irq_pulse=0; synchroniser flops cleared.
REQ-023 Reset asserted during a transaction SHALL abort it with no rsp_valid; that transaction SHALL never be completed after reset.

Verification
REQ-024 Reset release with defaults -> OTG_RST_N low for 4 cycles, then req_ready=1.
REQ-025 Write, addr=2, wdata=16'hBEEF, defaults -> CS_N low 4 cycles; WR_N low for cycles 2-3; OTG_DATA=BEEF for those 4 cycles, Z otherwise; rsp_valid 5 cycles after acceptance.
REQ-026 Read, addr=1, device drives 16'h1234 during STROBE -> RD_N low 2 cycles; OTG_DATA Z throughout; rsp_rdata=1234 with the rsp_valid pulse.
REQ-027 Two requests held back-to-back -> second accepted in the first rsp_valid cycle; no idle gap beyond it; strobes never both low.
REQ-028 Reset pulsed in STROBE of a write -> WR_N and CS_N go 1 and OTG_DATA goes Z asynchronously; no rsp_valid; RSTWAIT sequence repeats.
REQ-029 OTG_INT rises asynchronously, held 10 cycles -> irq_level high 2-3 cycles later; exactly one irq_pulse.

Source files
------------

// File: rtl/hpi_bus_master.sv
// Host-port bus master: sequences SETUP/STROBE/HOLD read and write cycles on an OTG-style
// parallel host interface, holds the device in reset after power-up, and synchronises its IRQ.
`timescale 1ns / 1ps
module hpi_bus_master #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RST_CYC    = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              irq_level,
  output logic              irq_pulse,
  inout  wire  [DATA_W-1:0] OTG_DATA,
  output logic [ADDR_W-1:0] OTG_ADDR,
  output logic              OTG_RD_N,
  output logic              OTG_WR_N,
  output logic              OTG_CS_N,
  output logic              OTG_RST_N,
  input  logic              OTG_INT
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : gen_chk_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : gen_chk_strobe
    $error("STROBE_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : gen_chk_hold
    $error("HOLD_CYC must be in 1..15");
  end
  if (RST_CYC < 1 || RST_CYC > 255) begin : gen_chk_rst
    $error("RST_CYC must be in 1..255");
  end

  localparam logic [7:0] SetupLast  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] StrobeLast = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HoldLast   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RstCnt     = 8'(RST_CYC);

  typedef enum logic [2:0] {StRstWait, StIdle, StSetup, StStrobe, StHold} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cs_n_q, rd_n_q, wr_n_q, rst_n_q, drive_q, rsp_valid_q;
  logic                cs_n_d, rd_n_d, wr_n_d, rst_n_d, drive_d, rsp_valid_d;
  logic                in_txn_d, capture;
  logic [DATA_W-1:0]   rdata_q;
  logic                sync1_q, sync2_q, irq_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      // Counting starts on the first edge after release, so the device sees RST_CYC full cycles.
      StRstWait: begin
        if (cnt_q == RstCnt) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StRstWait;
        cnt_d   = '0;
      end
    endcase

    // Pin values are derived from the next state so the registered pins line up with the state.
    in_txn_d    = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    cs_n_d      = !in_txn_d;
    rd_n_d      = !((state_d == StStrobe) && !write_d);
    wr_n_d      = !((state_d == StStrobe) && write_d);
    drive_d     = in_txn_d && write_d;
    rst_n_d     = (state_d != StRstWait);
    rsp_valid_d = (state_q == StHold) && (state_d == StIdle);
    capture     = (state_q == StStrobe) && (cnt_q == StrobeLast) && !write_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StRstWait;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rst_n_q     <= 1'b0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      rst_n_q     <= rst_n_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
      if (capture) begin
        rdata_q <= OTG_DATA;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      irq_prev_q <= 1'b0;
    end else begin
      sync1_q    <= OTG_INT;
      sync2_q    <= sync1_q;
      irq_prev_q <= sync2_q;
    end
  end

  assign OTG_DATA  = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign OTG_ADDR  = addr_q;
  assign OTG_CS_N  = cs_n_q;
  assign OTG_RD_N  = rd_n_q;
  assign OTG_WR_N  = wr_n_q;
  assign OTG_RST_N = rst_n_q;
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign irq_level = sync2_q;
  assign irq_pulse = sync2_q & ~irq_prev_q;

endmodule

// File: tb/tb_hpi_bus_master.sv
// Randomised bench for hpi_bus_master: a cycle schedule derived from the SETUP/STROBE/HOLD
// timing rules predicts every pin each cycle; a simple device model drives the shared bus.
`timescale 1ns / 1ps
module tb_hpi_bus_master;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 2;
  localparam int unsigned S  = 1;
  localparam int unsigned T  = 2;
  localparam int unsigned H  = 1;
  localparam int unsigned R  = 4;
  localparam int          L  = S + T + H;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          irq_level;
  logic          irq_pulse;
  wire  [DW-1:0] OTG_DATA;
  logic [AW-1:0] OTG_ADDR;
  logic          OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N;
  logic          OTG_INT = 1'b0;

  // Device side of the bus: drives whenever the master is expected to be released.
  logic          dev_en = 1'b1;
  logic [DW-1:0] dev_data = '0;
  assign OTG_DATA = dev_en ? dev_data : {DW{1'bz}};

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_rdata = '0;

  hpi_bus_master #(
    .DATA_W(DW), .ADDR_W(AW), .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RST_CYC(R)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq_level(irq_level),
    .irq_pulse(irq_pulse), .OTG_DATA(OTG_DATA), .OTG_ADDR(OTG_ADDR), .OTG_RD_N(OTG_RD_N),
    .OTG_WR_N(OTG_WR_N), .OTG_CS_N(OTG_CS_N), .OTG_RST_N(OTG_RST_N), .OTG_INT(OTG_INT)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no end, required $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %h required %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic assert_reset();
    Reset    = 1'b1;
    dev_en   = 1'b1;
    dev_data = 16'($urandom);
    #1;
    check("rst_otg_rst_n", OTG_RST_N, 0);
    check("rst_cs_n", OTG_CS_N, 1);
    check("rst_rd_n", OTG_RD_N, 1);
    check("rst_wr_n", OTG_WR_N, 1);
    check("rst_addr", OTG_ADDR, 0);
    check("rst_bus_released", OTG_DATA, dev_data);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_irq_level", irq_level, 0);
    check("rst_irq_pulse", irq_pulse, 0);
    last_rdata = '0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 1; i <= R + 1; i++) begin
      @(negedge Clk);
      check("rstwait_otg_rst_n", OTG_RST_N, (i > R));
      check("rstwait_ready", req_ready, (i > R));
      check("rstwait_rsp_valid", rsp_valid, 0);
      check("rstwait_cs_n", OTG_CS_N, 1);
    end
  endtask

  task automatic idle_cycle();
    @(posedge Clk);
    #1;
    dev_en   = 1'b1;
    dev_data = 16'($urandom);
    @(negedge Clk);
    check("idle_cs_n", OTG_CS_N, 1);
    check("idle_ready", req_ready, 1);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_bus_released", OTG_DATA, dev_data);
  endtask

  // Called at a falling edge. Cycle k=1 is the first cycle after the accepting edge; the master
  // owns the bus for k=1..L, the strobe is low for k=S+1..S+T, and the response shows at k=L+1.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rv, input logic keep, input int abort_k,
                         output int waits);
    logic in_txn, strobe;
    waits     = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready) begin
      if (waits >= 20) begin
        check("accept_timeout_waits", waits, 0);
        req_valid = 1'b0;
        return;
      end
      @(posedge Clk);
      #1;
      @(negedge Clk);
      waits++;
    end
    @(posedge Clk);
    #1;
    if (!keep) req_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      if (k > 1) begin
        @(posedge Clk);
        #1;
      end
      in_txn = (k <= L);
      strobe = (k > S) && (k <= S + T);
      if (w && in_txn) begin
        dev_en = 1'b0;
      end else begin
        dev_en   = 1'b1;
        dev_data = (!w && strobe) ? rv : 16'($urandom);
      end
      @(negedge Clk);
      check("txn_cs_n", OTG_CS_N, !in_txn);
      check("txn_rd_n", OTG_RD_N, !(!w && strobe));
      check("txn_wr_n", OTG_WR_N, !(w && strobe));
      check("txn_ready", req_ready, !in_txn);
      check("txn_rsp_valid", rsp_valid, (k == L + 1));
      check("txn_otg_rst_n", OTG_RST_N, 1);
      check("txn_bus", OTG_DATA, (w && in_txn) ? wd : dev_data);
      if (in_txn) check("txn_addr", OTG_ADDR, a);
      if (k == L + 1) begin
        if (!w) last_rdata = rv;
        check("txn_rsp_rdata", rsp_rdata, last_rdata);
      end
      if (k == abort_k) begin
        #2;
        assert_reset();
        req_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic irq_test();
    int first_high = -1;
    int pulses = 0;
    int d = $urandom_range(1, 4);
    @(negedge Clk);
    #(d);
    OTG_INT = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (irq_level && first_high < 0) first_high = c;
      if (irq_pulse) pulses++;
      if (c == 10) OTG_INT = 1'b0;
    end
    check("irq_level_latency_2_to_3", (first_high >= 2 && first_high <= 3), 1);
    check("irq_pulse_count", pulses, 1);
    check("irq_level_fall", irq_level, 0);
  endtask

  initial begin
    int   waits;
    logic w, keep, prev_keep;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rv;

    #2;
    assert_reset();
    release_reset();

    run_txn(1'b1, 2'd2, 16'hBEEF, 16'h0000, 1'b0, 0, waits);
    check("beef_accept_wait", waits, 0);
    idle_cycle();
    run_txn(1'b0, 2'd1, 16'h0000, 16'h1234, 1'b0, 0, waits);
    idle_cycle();

    run_txn(1'b1, 2'd3, 16'h0F0F, 16'h0000, 1'b1, 0, waits);
    run_txn(1'b0, 2'd0, 16'h0000, 16'hCAFE, 1'b0, 0, waits);
    check("b2b_gap", waits, 0);

    prev_keep = 1'b0;
    for (int i = 0; i < 24; i++) begin
      w    = 1'($urandom_range(0, 1));
      a    = 2'($urandom_range(0, 3));
      wd   = 16'($urandom);
      rv   = 16'($urandom);
      keep = (i < 23) && ($urandom_range(0, 2) == 0);
      run_txn(w, a, wd, rv, keep, 0, waits);
      if (prev_keep) check("rand_b2b_gap", waits, 0);
      prev_keep = keep;
      if (!keep) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) idle_cycle();
      end
    end

    run_txn(1'b1, 2'd1, 16'hA5A5, 16'h0000, 1'b0, S + 1, waits);
    release_reset();
    repeat (3) idle_cycle();
    run_txn(1'b0, 2'd2, 16'h0000, 16'h5AC3, 1'b0, 0, waits);

    irq_test();
    irq_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
